apb_mem_slave: RTL and testbench
================================

Name: apb_mem_slave

Overview:
- Parametrised APB4 memory slave: the next generation of the fixed-width APB memory.
- Adds configurable data width, depth and wait states, and byte strobes (pstrb).
- Signals PSLVERR on out-of-range addresses.
- Detects protocol violations on the bus and raises a sticky flag.
- Sits behind the APB bridge/decoder as a word-addressed scratch RAM; the existing driver and monitor interface style applies.

Parameters:
ADDR_W, 12, byte-address width of paddr (word index = paddr[ADDR_W-1:2])
DATA_W, 32, data width; legal values 8, 16, 32, 64; pstrb width = DATA_W/8
DEPTH, 256, number of words; must be ≤ 2^(ADDR_W-2)
WAIT_STATES, 0, extra access cycles before pready, range 0..15

Ports:
pclk  input  1  bus clock, all logic on rising edge
prst  input  1  reset; one clock; reset is asynchronous and active-low
psel  input  1  slave select
penable  input  1  access phase strobe
pwrite  input  1  1 = write, 0 = read
paddr  input  ADDR_W  byte address; bits [1:0] ignored
pwdata  input  DATA_W  write data
pstrb  input  DATA_W/8  byte write strobes (ignored on reads)
prdata  output  DATA_W  read data
pready  output  1  transfer completion
pslverr  output  1  transfer error, valid only with pready
proto_err  output  1  sticky protocol-violation flag
proto_clr  input  1  synchronous clear of proto_err

Behaviour:
- Reset (prst=0, asynchronous): state=IDLE, wait_cnt=0, prdata=0, pready=0, pslverr=0, proto_err=0. Memory contents are not reset.
- States: IDLE, ACCESS.
- pready = (state==ACCESS) && (wait_cnt==0). pslverr = pready && err_q. Both are 0 in IDLE.
- Setup capture: at an edge in IDLE with psel=1, penable=0:
  - latch addr, pwrite, pwdata, pstrb;
  - err_q = (word index ≥ DEPTH);
  - wait_cnt = WAIT_STATES;
  - if read && !err: prdata ← mem[index]; if read && err: prdata ← 0;
  - state → ACCESS.
- Read data is therefore valid from the first access cycle. prdata holds its value until the next read capture.
- ACCESS, pready=0: requires psel=1, penable=1, and paddr/pwrite unchanged from the latched values.
  - If satisfied: wait_cnt decrements.
  - Otherwise: proto_err ← 1, transfer aborted (no write), state → IDLE.
- ACCESS, pready=1 at an edge, same checks:
  - write && !err: mem[index] bytes with pstrb[i]=1 ← latched pwdata bytes; other bytes unchanged;
  - state → IDLE.
- Back-to-back: setup can follow in the cycle after completion; there is no dead cycle beyond the APB-mandated setup.
- IDLE with psel=1, penable=1 (access without setup): proto_err ← 1, pready stays 0, no memory effect.
- Write latency: data is visible to a read whose setup edge comes after the completing edge.
- Read latency: WAIT_STATES+1 access cycles; total transfer length 2+WAIT_STATES cycles.
- proto_clr=1 clears proto_err at the edge. If a violation occurs on the same edge, set wins.
- Reset mid-transfer: pready drops immediately, FSM returns to IDLE, pending write is discarded.
- wait_cnt is 4 bits wide. WAIT_STATES=0 gives pready in the first access cycle.

Decomposition:
- Package apb_mem_pkg holds:
  - state enum (IDLE, ACCESS);
  - default parameter constants;
  - function for strobe width (DATA_W/8).
- Sub-module apb_mem_array holds storage: DEPTH×DATA_W, synchronous read on a read enable, byte-enable write, no reset.
- The FSM, wait counter, error and protocol logic live in apb_mem_slave.

Test Plan:
1. WAIT_STATES=2; write 0x040 ← 0xDEADBEEF, pstrb=0xF; then read 0x040 -> pready high in the 3rd access cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
2. Write 0x040 ← 0x0000CAFE with pstrb=0x3; read 0x040 -> prdata=0xDEADCAFE.
3. DEPTH=256: write 0x400 ← 0x12345678, then read 0x400 -> both give pslverr=1 with pready, read prdata=0; read 0x000 unaffected.
4. Drop penable during a wait state of a write to 0x010 -> proto_err=1, FSM back to IDLE, later read of 0x010 returns the old value; psel+penable with no setup also sets proto_err; proto_clr pulse -> proto_err=0.
5. Assert prst low during the wait of a write to 0x020 (data 0xA5A5A5A5) -> pready=0 asynchronously, all outputs at reset values, word 0x020 not modified.
6. WAIT_STATES=0, DATA_W=64: back-to-back write 0x008 ← 0x0123456789ABCDEF, then read 0x008 -> pready in the first access cycle each time, prdata matches.

Source files
------------

// File: rtl/apb_mem_pkg.sv
// Shared types, defaults and helpers for the parametrised APB4 scratch-RAM slave.
package apb_mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEPTH       = 256;
  localparam int DEF_WAIT_STATES = 0;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word storage: registered read on rd_en, byte-enabled write, contents never reset.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = 8
) (
  input  logic                        pclk,
  input  logic                        rd_en,
  input  logic [AW-1:0]               rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [strb_w(DATA_W)-1:0]   wr_be
);

  localparam int STRB_W = strb_w(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge pclk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 word-addressed scratch RAM with wait states, byte strobes, PSLVERR on
// out-of-range words and a sticky protocol-violation flag.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  proto_err,
  input  logic                  proto_clr
);

  localparam int IDX_W          = ADDR_W - 2;
  localparam int AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int STRB_W         = strb_w(DATA_W);
  localparam logic [3:0] WS     = 4'(WAIT_STATES);
  localparam logic [IDX_W:0] DEPTH_V = (IDX_W+1)'(DEPTH);

  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("apb_mem_slave: DATA_W must be 8, 16, 32 or 64");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("apb_mem_slave: WAIT_STATES must be 0..15");
  end
  if (DEPTH < 1 || DEPTH > (1 << IDX_W)) begin : g_bad_depth
    $error("apb_mem_slave: DEPTH must fit in the word index space");
  end

  state_t              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic                err_q;
  logic                proto_q, proto_d;
  logic                rd_zero_q;

  logic                capture;
  logic                viol;
  logic                acc_ok;
  logic                addr_err;
  logic                mem_re;
  logic                mem_we;
  logic [IDX_W-1:0]    idx_in;
  logic [DATA_W-1:0]   mem_rdata;

  assign idx_in   = paddr[ADDR_W-1:2];
  assign addr_err = ({1'b0, idx_in} >= DEPTH_V);
  assign acc_ok   = psel && penable && (paddr == addr_q) && (pwrite == write_q);

  assign pready    = (state_q == ACCESS) && (wait_q == 4'd0);
  assign pslverr   = pready && err_q;
  assign proto_err = proto_q;
  // Storage has no reset, so reset and error reads are forced to zero here.
  assign prdata    = rd_zero_q ? '0 : mem_rdata;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    capture = 1'b0;
    viol    = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          capture = 1'b1;
          mem_re  = !pwrite && !addr_err;
          wait_d  = WS;
          state_d = ACCESS;
        end else if (psel && penable) begin
          viol = 1'b1;
        end
      end
      ACCESS: begin
        if (!acc_ok) begin
          viol    = 1'b1;
          state_d = IDLE;
        end else if (pready) begin
          mem_we  = write_q && !err_q;
          state_d = IDLE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A violation on the clearing edge wins.
    proto_d = viol ? 1'b1 : (proto_clr ? 1'b0 : proto_q);
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      proto_q <= proto_d;
    end
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      rd_zero_q <= 1'b1;
    end else if (capture) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
      err_q   <= addr_err;
      if (!pwrite) rd_zero_q <= addr_err;
    end
  end

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .pclk    (pclk),
    .rd_en   (mem_re),
    .rd_addr (paddr[AW+1:2]),
    .rd_data (mem_rdata),
    .wr_en   (mem_we),
    .wr_addr (addr_q[AW+1:2]),
    .wr_data (wdata_q),
    .wr_be   (strb_q)
  );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench: a 32-bit/2-wait instance and a 64-bit/0-wait instance.
module tb_apb_mem_slave;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        prst;

  logic        psel0, penable0, pwrite0, proto_clr0;
  logic [11:0] paddr0;
  logic [31:0] pwdata0;
  logic [3:0]  pstrb0;
  logic [31:0] prdata0;
  logic        pready0, pslverr0, proto_err0;

  logic        psel1, penable1, pwrite1, proto_clr1;
  logic [11:0] paddr1;
  logic [63:0] pwdata1;
  logic [7:0]  pstrb1;
  logic [63:0] prdata1;
  logic        pready1, pslverr1, proto_err1;

  apb_mem_slave #(.ADDR_W(12), .DATA_W(32), .DEPTH(256), .WAIT_STATES(2)) dut (
    .pclk(pclk), .prst(prst), .psel(psel0), .penable(penable0), .pwrite(pwrite0),
    .paddr(paddr0), .pwdata(pwdata0), .pstrb(pstrb0), .prdata(prdata0),
    .pready(pready0), .pslverr(pslverr0), .proto_err(proto_err0), .proto_clr(proto_clr0)
  );

  apb_mem_slave #(.ADDR_W(12), .DATA_W(64), .DEPTH(256), .WAIT_STATES(0)) dut64 (
    .pclk(pclk), .prst(prst), .psel(psel1), .penable(penable1), .pwrite(pwrite1),
    .paddr(paddr1), .pwdata(pwdata1), .pstrb(pstrb1), .prdata(prdata1),
    .pready(pready1), .pslverr(pslverr1), .proto_err(proto_err1), .proto_clr(proto_clr1)
  );

  typedef struct {
    bit          is_rd;
    logic [63:0] data;
    bit          err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop an expected response whenever a slave completes a transfer.
  always @(negedge pclk) begin
    if (pready0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon0_unexpected: got pready=1 expected no transfer");
      end else begin
        e0 = q0.pop_front();
        check("mon0_pslverr", {63'd0, pslverr0}, {63'd0, e0.err});
        if (e0.is_rd) check("mon0_prdata", {32'd0, prdata0}, {32'd0, e0.data[31:0]});
      end
    end
  end

  always @(negedge pclk) begin
    if (pready1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon1_unexpected: got pready=1 expected no transfer");
      end else begin
        e1 = q1.pop_front();
        check("mon1_pslverr", {63'd0, pslverr1}, {63'd0, e1.err});
        if (e1.is_rd) check("mon1_prdata", prdata1, e1.data);
      end
    end
  end

  task automatic idle(input int n);
    psel0 = 1'b0; penable0 = 1'b0;
    psel1 = 1'b0; penable1 = 1'b0;
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // One APB transfer; also checks the number of access cycles up to pready.
  task automatic xfer(input bit b64, input bit wr, input logic [11:0] a,
                      input logic [63:0] wd, input logic [7:0] st,
                      input logic [63:0] exp_rd, input bit exp_err,
                      input int exp_cyc, input string name);
    exp_t e;
    int   cyc;
    bit   done;
    e.is_rd = !wr; e.data = exp_rd; e.err = exp_err;
    if (b64) begin
      q1.push_back(e);
      psel1 = 1'b1; penable1 = 1'b0; pwrite1 = wr; paddr1 = a; pwdata1 = wd; pstrb1 = st;
    end else begin
      q0.push_back(e);
      psel0 = 1'b1; penable0 = 1'b0; pwrite0 = wr; paddr0 = a; pwdata0 = wd[31:0]; pstrb0 = st[3:0];
    end
    @(posedge pclk); #1;
    if (b64) penable1 = 1'b1; else penable0 = 1'b1;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge pclk);
      cyc++;
      done = b64 ? (pready1 === 1'b1) : (pready0 === 1'b1);
    end
    check({name, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    @(posedge pclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    psel0 = 0; penable0 = 0; pwrite0 = 0; paddr0 = '0; pwdata0 = '0; pstrb0 = '0; proto_clr0 = 0;
    psel1 = 0; penable1 = 0; pwrite1 = 0; paddr1 = '0; pwdata1 = '0; pstrb1 = '0; proto_clr1 = 0;
    prst = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("rst_pready0",  {63'd0, pready0},    64'd0);
    check("rst_pslverr0", {63'd0, pslverr0},   64'd0);
    check("rst_proto0",   {63'd0, proto_err0}, 64'd0);
    check("rst_prdata0",  {32'd0, prdata0},    64'd0);
    check("rst_pready1",  {63'd0, pready1},    64'd0);
    check("rst_prdata1",  prdata1,             64'd0);
    @(posedge pclk); #1;
    prst = 1'b1;
    idle(1);

    // Full write then read, two wait states.
    xfer(0, 1, 12'h040, 64'hDEADBEEF, 8'hF, 64'h0, 0, 3, "t1_wr");
    xfer(0, 0, 12'h040, 64'h0, 8'h0, 64'hDEADBEEF, 0, 3, "t1_rd");
    // Low-half strobe write.
    xfer(0, 1, 12'h040, 64'h0000CAFE, 8'h3, 64'h0, 0, 3, "t2_wr");
    xfer(0, 0, 12'h040, 64'h0, 8'h0, 64'hDEADCAFE, 0, 3, "t2_rd");
    idle(1);

    // Out-of-range word must error and must not alias onto word 0.
    xfer(0, 1, 12'h000, 64'h0BADF00D, 8'hF, 64'h0, 0, 3, "t3_wr0");
    xfer(0, 1, 12'h400, 64'h12345678, 8'hF, 64'h0, 1, 3, "t3_wr_oor");
    xfer(0, 0, 12'h400, 64'h0, 8'h0, 64'h0, 1, 3, "t3_rd_oor");
    xfer(0, 0, 12'h000, 64'h0, 8'h0, 64'h0BADF00D, 0, 3, "t3_rd0");
    xfer(0, 1, 12'h044, 64'h55555555, 8'hF, 64'h0, 0, 3, "t3_wr44");
    idle(2);
    check("t3_prdata_hold", {32'd0, prdata0}, 64'h0BADF00D);

    // Aborted write: penable dropped during a wait state.
    xfer(0, 1, 12'h010, 64'h11112222, 8'hF, 64'h0, 0, 3, "t4_wr");
    idle(1);
    psel0 = 1; penable0 = 0; pwrite0 = 1; paddr0 = 12'h010; pwdata0 = 32'h99999999; pstrb0 = 4'hF;
    @(posedge pclk); #1; penable0 = 1;
    @(posedge pclk); #1; penable0 = 0;
    @(posedge pclk); #1; psel0 = 0;
    @(negedge pclk);
    check("t4_proto_set",  {63'd0, proto_err0}, 64'd1);
    check("t4_pready_low", {63'd0, pready0},    64'd0);
    idle(1);
    xfer(0, 0, 12'h010, 64'h0, 8'h0, 64'h11112222, 0, 3, "t4_rd_old");
    idle(1);
    check("t4_proto_sticky", {63'd0, proto_err0}, 64'd1);
    proto_clr0 = 1;
    @(posedge pclk); #1; proto_clr0 = 0;
    check("t4_proto_clr", {63'd0, proto_err0}, 64'd0);
    // Access phase without setup.
    psel0 = 1; penable0 = 1; pwrite0 = 0; paddr0 = 12'h000;
    @(posedge pclk); #1; psel0 = 0; penable0 = 0;
    check("t4_nosetup_proto",  {63'd0, proto_err0}, 64'd1);
    check("t4_nosetup_pready", {63'd0, pready0},    64'd0);
    // Violation on the clearing edge keeps the flag set.
    psel0 = 1; penable0 = 1; proto_clr0 = 1;
    @(posedge pclk); #1; psel0 = 0; penable0 = 0; proto_clr0 = 0;
    check("t4_set_wins", {63'd0, proto_err0}, 64'd1);
    idle(1);

    // Reset asserted while the write is completing.
    xfer(0, 1, 12'h020, 64'h01020304, 8'hF, 64'h0, 0, 3, "t5_wr_old");
    xfer(0, 0, 12'h010, 64'h0, 8'h0, 64'h11112222, 0, 3, "t5_rd_pre");
    idle(1);
    psel0 = 1; penable0 = 0; pwrite0 = 1; paddr0 = 12'h020; pwdata0 = 32'hA5A5A5A5; pstrb0 = 4'hF;
    @(posedge pclk); #1; penable0 = 1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    check("t5_pready_before", {63'd0, pready0}, 64'd1);
    #1 prst = 1'b0;
    #1;
    check("t5_rst_pready",  {63'd0, pready0},    64'd0);
    check("t5_rst_pslverr", {63'd0, pslverr0},   64'd0);
    check("t5_rst_proto",   {63'd0, proto_err0}, 64'd0);
    check("t5_rst_prdata",  {32'd0, prdata0},    64'd0);
    psel0 = 0; penable0 = 0;
    @(posedge pclk); #1; prst = 1'b1;
    idle(1);
    xfer(0, 0, 12'h020, 64'h0, 8'h0, 64'h01020304, 0, 3, "t5_rd");
    idle(1);

    // 64-bit, zero wait states, back-to-back.
    xfer(1, 1, 12'h008, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 0, 1, "t6_wr");
    xfer(1, 0, 12'h008, 64'h0, 8'h0, 64'h0123456789ABCDEF, 0, 1, "t6_rd");
    xfer(1, 1, 12'h008, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'h0, 0, 1, "t6_wr_lo");
    xfer(1, 0, 12'h008, 64'h0, 8'h0, 64'h01234567FFFFFFFF, 0, 1, "t6_rd_lo");
    idle(3);

    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
